frame_collector: RTL and testbench
==================================

// Module: frame_collector
// PURPOSE
// Upstream stage of the FFT/argmax analysis block. Collects a stream of signed 16-bit
// audio samples, optionally decimated, into an FFT-deep sliding window. Every HOP
// accepted samples it presents a stable frame and a one-cycle start pulse to the
// analysis block. Frames arriving while analysis is still busy are dropped and counted.
// PARAMETERS
// FFT    8   frame length in samples; must match the analysis block's FFT
// HOP    4   new samples between frames; 1 <= HOP <= FFT
// DECIM  1   accept 1 of every DECIM valid samples; DECIM >= 1
// OVR_W  8   width of the dropped-frame counter
// PORTS
// i_clk             in   1          system clock, rising edge
// i_rst_n           in   1          asynchronous active-low reset
// i_sample_valid    in   1          i_sample is valid this cycle
// i_sample          in   16 signed  audio sample, two's complement
// i_flush           in   1          discard the window and restart filling
// i_dsp_done        in   1          analysis-finish pulse from the analysis block
// o_frame[FFT]      out  16 signed  frame to analysis; [0] oldest, [FFT-1] newest
// o_start           out  1          one-cycle frame-start pulse
// o_busy            out  1          analysis in progress (start issued, done not yet seen)
// o_frames_dropped  out  OVR_W      saturating count of frames dropped while busy
// BEHAVIOUR
// - Reset (async, i_rst_n=0): window, o_frame, o_start, o_busy, o_frames_dropped, all
//   counters -> 0; state -> S_FILL. A reset mid-fill or mid-analysis discards everything.
// - Decimation: dec_cnt runs 0..DECIM-1 and advances on each i_sample_valid.
//   A sample is accepted iff valid && dec_cnt==0.
// - Accepted sample: window shifts toward index 0; win[FFT-1] <= i_sample.
// - FSM:
//   S_FILL: fill_cnt counts accepted samples. On the accept that makes fill_cnt==FFT,
//     a frame is due; go to S_RUN with hop_cnt=0.
//   S_RUN: hop_cnt counts accepted samples. On the accept that makes hop_cnt==HOP,
//     a frame is due and hop_cnt is cleared to 0.
// - Frame due at edge E:
//   - If !o_busy || i_dsp_done at E: o_frame <= post-shift window (including the sample
//     accepted at E); o_start=1 for exactly the cycle after E; o_busy <= 1.
//   - Otherwise: the frame is dropped, o_frames_dropped += 1 saturating at 2^OVR_W-1,
//     and o_frame is unchanged.
// - Latency: o_start rises 1 cycle after the clock edge that accepted the completing sample.
// - o_frame holds stable from o_start until the next o_start. The analysis block
//   latches it in its idle state.
// - o_busy: set on issue; cleared on i_dsp_done when no frame issues that cycle.
//   i_dsp_done while !o_busy is ignored.
// - i_flush (synchronous): fill_cnt, hop_cnt, dec_cnt -> 0; state -> S_FILL.
//   Window contents, o_frame, o_busy and o_frames_dropped are kept.
//   A sample presented in the same cycle as i_flush is discarded.
//   Flush has priority over a frame-due event.
// - Sample width: stored unmodified, 16-bit signed; no scaling, no rounding.
// TESTING (FFT=8, HOP=4, DECIM=1, OVR_W=8 unless stated)
// 1 Reset; samples 1..8, valid every cycle; no done -> o_start one cycle after the 8th
//   accept; o_frame=[1,2,...,8]; o_busy=1; o_start high exactly 1 cycle.
// 2 Continue with 9..12 while busy -> no o_start, dropped=1; pulse done, then feed
//   13..16 -> o_start, o_frame=[9..16], dropped stays 1.
// 3 Hop completes in the same cycle as i_dsp_done -> o_start issued, o_busy stays 1,
//   dropped unchanged.
// 4 DECIM=2; valid samples 1..16 back-to-back -> first frame=[1,3,5,...,15].
// 5 i_flush after 5 accepts, sample 6 presented in the flush cycle -> sample 6 discarded;
//   o_start only after 8 further accepts.
// 6 OVR_W=2; force 5 dropped frames -> dropped saturates at 3. Assert i_rst_n low
//   mid-fill -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/frame_collector.sv
// frame_collector: gathers (optionally decimated) samples into a sliding FFT window and
// issues a frame with a start pulse every HOP accepted samples, dropping frames while busy.
module frame_collector #(
  parameter int FFT   = 8,
  parameter int HOP   = 4,
  parameter int DECIM = 1,
  parameter int OVR_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sample_valid,
  input  logic signed [15:0]  i_sample,
  input  logic                i_flush,
  input  logic                i_dsp_done,
  output logic signed [15:0]  o_frame [FFT],
  output logic                o_start,
  output logic                o_busy,
  output logic [OVR_W-1:0]    o_frames_dropped
);
  localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int FW = $clog2(FFT + 1);
  localparam int HW = $clog2(HOP + 1);
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state;
  logic [DW-1:0]      dec_cnt;
  logic [FW-1:0]      fill_cnt;
  logic [HW-1:0]      hop_cnt;
  logic signed [15:0] win      [FFT];
  logic signed [15:0] win_next [FFT];
  logic               accept, due, issue;

  // window as it will look after shifting in the current sample
  always_comb begin
    for (int i = 0; i < FFT - 1; i++) win_next[i] = win[i+1];
    win_next[FFT-1] = i_sample;
  end

  assign accept = i_sample_valid && dec_cnt == '0 && !i_flush;
  assign due    = accept && (state == S_FILL ? fill_cnt == FW'(FFT - 1) : hop_cnt == HW'(HOP - 1));
  assign issue  = due && (!o_busy || i_dsp_done);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_FILL;
      dec_cnt          <= '0;
      fill_cnt         <= '0;
      hop_cnt          <= '0;
      o_start          <= 1'b0;
      o_busy           <= 1'b0;
      o_frames_dropped <= '0;
      for (int i = 0; i < FFT; i++) begin
        win[i]     <= '0;
        o_frame[i] <= '0;
      end
    end else begin
      o_start <= issue;
      if (issue) o_busy <= 1'b1;
      else if (i_dsp_done) o_busy <= 1'b0;
      if (issue) o_frame <= win_next;
      if (due && !issue && o_frames_dropped != '1) o_frames_dropped <= o_frames_dropped + 1'b1;
      if (i_flush) begin
        dec_cnt  <= '0;
        fill_cnt <= '0;
        hop_cnt  <= '0;
        state    <= S_FILL;
      end else begin
        if (i_sample_valid) dec_cnt <= dec_cnt == DW'(DECIM - 1) ? '0 : dec_cnt + 1'b1;
        if (accept) begin
          win <= win_next;
          if (state == S_FILL) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (due) begin
              state   <= S_RUN;
              hop_cnt <= '0;
            end
          end else begin
            hop_cnt <= due ? '0 : hop_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_frame_collector.sv
// tb_frame_collector: directed checks of frame_collector in three parameterisations
// (default, DECIM=2, OVR_W=2) sharing one stimulus bus.
module tb_frame_collector;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               valid = 1'b0;
  logic signed [15:0] sample = '0;
  logic               flush = 1'b0;
  logic               done = 1'b0;
  logic signed [15:0] f1 [8];
  logic signed [15:0] f2 [8];
  logic signed [15:0] f3 [8];
  logic               st1, st2, st3, bz1, bz2, bz3;
  logic [7:0]         dr1, dr2;
  logic [1:0]         dr3;
  int                 n_chk = 0;
  int                 n_pass = 0;
  logic               seen;

  always #5 clk = ~clk;

  frame_collector #(.FFT(8), .HOP(4), .DECIM(1), .OVR_W(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(valid), .i_sample(sample),
    .i_flush(flush), .i_dsp_done(done), .o_frame(f1), .o_start(st1), .o_busy(bz1),
    .o_frames_dropped(dr1));
  frame_collector #(.FFT(8), .HOP(4), .DECIM(2), .OVR_W(8)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(valid), .i_sample(sample),
    .i_flush(flush), .i_dsp_done(done), .o_frame(f2), .o_start(st2), .o_busy(bz2),
    .o_frames_dropped(dr2));
  frame_collector #(.FFT(8), .HOP(4), .DECIM(1), .OVR_W(2)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(valid), .i_sample(sample),
    .i_flush(flush), .i_dsp_done(done), .o_frame(f3), .o_start(st3), .o_busy(bz3),
    .o_frames_dropped(dr3));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] pk(input logic signed [15:0] f [8]);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = f[i];
    return r;
  endfunction

  function automatic logic [127:0] seq(input int first, input int stp);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(first + i * stp);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    valid  = 1'b1;
    sample = 16'(v);
    step();
    valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    flush = 1'b0;
    done  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_start", st1, 0);
    check("rst_busy", bz1, 0);
    check("rst_drop", dr1, 0);
    check("rst_frame", pk(f1), 0);

    // first frame after 8 accepts
    seen = 1'b0;
    for (int v = 1; v <= 7; v++) begin push(v); seen |= st1; end
    check("fill_nostart", seen, 0);
    push(8);
    check("t1_start", st1, 1);
    check("t1_frame", pk(f1), seq(1, 1));
    check("t1_busy", bz1, 1);
    step();
    check("t1_pulse1", st1, 0);

    // hop while busy is dropped
    for (int v = 9; v <= 12; v++) push(v);
    check("t2_nostart", st1, 0);
    check("t2_drop", dr1, 1);
    check("t2_frame_kept", pk(f1), seq(1, 1));
    done = 1'b1;
    step();
    done = 1'b0;
    check("t2_busy_clr", bz1, 0);
    for (int v = 13; v <= 16; v++) push(v);
    check("t2_start", st1, 1);
    check("t2_frame", pk(f1), seq(9, 1));
    check("t2_drop_same", dr1, 1);

    // hop completing together with done
    for (int v = 17; v <= 19; v++) push(v);
    done = 1'b1;
    push(20);
    done = 1'b0;
    check("t3_start", st1, 1);
    check("t3_busy", bz1, 1);
    check("t3_frame", pk(f1), seq(13, 1));
    check("t3_drop", dr1, 1);
    step();
    check("t3_pulse1", st1, 0);
    check("t3_busy_hold", bz1, 1);

    // decimation by 2
    do_reset();
    seen = 1'b0;
    for (int v = 1; v <= 14; v++) begin push(v); seen |= st2; end
    check("t4_nostart", seen, 0);
    push(15);
    check("t4_start", st2, 1);
    check("t4_frame", pk(f2), seq(1, 2));
    push(16);
    check("t4_pulse1", st2, 0);

    // flush discards the sample presented with it
    do_reset();
    for (int v = 1; v <= 5; v++) push(v);
    flush = 1'b1;
    push(6);
    flush = 1'b0;
    seen = 1'b0;
    for (int v = 7; v <= 13; v++) begin push(v); seen |= st1; end
    check("t5_nostart", seen, 0);
    push(14);
    check("t5_start", st1, 1);
    check("t5_frame", pk(f1), seq(7, 1));

    // saturation and async reset
    do_reset();
    for (int v = 1; v <= 8; v++) push(v);
    check("t6_start", st3, 1);
    for (int v = 9; v <= 16; v++) push(v);
    check("t6_drop2", dr3, 2);
    for (int v = 17; v <= 28; v++) push(v);
    check("t6_sat", dr3, 3);
    push(29);
    push(30);
    check("t6_busy_pre", bz3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", dr3, 0);
    check("t6_async_busy", bz3, 0);
    check("t6_async_frame", pk(f3), 0);
    check("t6_async_start", st3, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
